// File: rtl/ram_stream_reader.sv
// ram_stream_reader: read-side sequencer for a 2048x8 simple dual-port RAM.
// Takes a burst command (start address, length) and issues one read per
// cycle while output credit allows. The registered read data is returned
// in address order on a valid/ready byte stream through a 3-entry
// first-word-fall-through buffer that absorbs the RAM's one-cycle latency.
// A read is only issued when the word it returns is guaranteed a free slot,
// counting both reads whose data has not yet been captured.

module ram_stream_reader #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 2048
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Start,
   input  logic [ADDR_W-1:0] StartAddr,
   input  logic [ADDR_W:0]   Len,
   output logic              Busy,
   output logic              Done,
   output logic [ADDR_W-1:0] RA,
   output logic              RdEn,
   input  logic [DATA_W-1:0] RD,
   output logic [DATA_W-1:0] DOut,
   output logic              DValid,
   input  logic              DReady
);

   localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam int                BUF_DEPTH = 3;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t state;
   state_t state_next;

   logic [ADDR_W-1:0] next_addr;
   logic [ADDR_W:0]   remaining;
   logic [ADDR_W-1:0] ra_q;
   logic              rd_en_q;
   logic              in_flight;
   logic              zero_done;

   logic [DATA_W-1:0] buf_mem [BUF_DEPTH];
   logic [1:0]        wr_ptr;
   logic [1:0]        rd_ptr;
   logic [1:0]        count;

   logic [ADDR_W:0]   len_clamped;
   logic              start_cmd;
   logic              start_burst;
   logic              start_empty;
   logic              push;
   logic              pop;
   logic [2:0]        outstanding;
   logic              credit_ok;
   logic              issue;
   logic              drain_done;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   assign len_clamped = (Len > LEN_MAX) ? LEN_MAX : Len;
   assign start_cmd   = (state == IDLE) && Start;
   assign start_burst = start_cmd && (len_clamped != '0);
   assign start_empty = start_cmd && (len_clamped == '0);

   assign push        = in_flight;
   assign pop         = (count != 2'd0) && DReady;
   assign outstanding = {1'b0, count} + {2'b00, in_flight} + {2'b00, rd_en_q};
   assign credit_ok   = outstanding <= (3'd2 + {2'b00, pop});
   assign issue       = (state == RUN) && (remaining != '0) && credit_ok;
   assign drain_done  = (state == DRAIN) && (count == 2'd0) && !in_flight && !rd_en_q;

   assign RA     = ra_q;
   assign RdEn   = rd_en_q;
   assign DOut   = buf_mem[rd_ptr];
   assign DValid = (count != 2'd0);

   // State register for the burst sequencer.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: RUN until every read is issued, DRAIN until the last word leaves.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (start_burst) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if ((remaining == '0) || (issue && (remaining == LEN_ONE))) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_done) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Status outputs: Busy drops in the same cycle Done pulses; empty bursts finish straight from IDLE.
   always_comb begin
      Busy = (state != IDLE) && !drain_done;
      Done = drain_done || zero_done;
   end

   // Read issue: latch the command, then step address and remaining count on every issued read.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         next_addr <= '0;
         remaining <= '0;
         ra_q      <= '0;
         rd_en_q   <= 1'b0;
         in_flight <= 1'b0;
         zero_done <= 1'b0;
      end else begin
         rd_en_q   <= 1'b0;
         in_flight <= rd_en_q;
         zero_done <= start_empty;
         if (start_burst) begin
            rd_en_q   <= 1'b1;
            ra_q      <= StartAddr;
            next_addr <= StartAddr + ADDR_ONE;
            remaining <= len_clamped - LEN_ONE;
         end else if (issue) begin
            rd_en_q   <= 1'b1;
            ra_q      <= next_addr;
            next_addr <= next_addr + ADDR_ONE;
            remaining <= remaining - LEN_ONE;
         end
      end
   end

   // Output buffer: capture RD the cycle after each read, pop on every stream transfer.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_mem[i] <= '0;
         end
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            buf_mem[wr_ptr] <= RD;
            wr_ptr          <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Testbench for ram_stream_reader: a behavioural RAM, a scoreboard of
// expected read addresses and stream bytes, a table of bursts run with the
// stream always ready, and hand sequences for backpressure, Start while
// busy, and reset in the middle of a burst.

module tb_ram_stream_reader;

   localparam int ADDR_W     = 11;
   localparam int DATA_W     = 8;
   localparam int DEPTH      = 2048;
   localparam int MAX_CYCLES = 2600;

   logic              Clk;
   logic              Rst;
   logic              Start;
   logic [ADDR_W-1:0] StartAddr;
   logic [ADDR_W:0]   Len;
   logic              Busy;
   logic              Done;
   logic [ADDR_W-1:0] RA;
   logic              RdEn;
   logic [DATA_W-1:0] RD;
   logic [DATA_W-1:0] DOut;
   logic              DValid;
   logic              DReady;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [ADDR_W:0]   len;
      int                words;
      int                done_ofs;
   } vec_t;

   vec_t vecs [6];

   logic [DATA_W-1:0] mem [DEPTH];
   logic [7:0]        data_key;

   logic [ADDR_W-1:0] ra_q   [$];
   logic [DATA_W-1:0] data_q [$];

   int n_compared   = 0;
   int n_mismatched = 0;
   int cyc          = 0;
   int iss_total    = 0;
   int iss_lag1     = 0;
   int xfer_total   = 0;
   int max_buf      = 0;
   int last_xfer_cyc = -1;
   bit track        = 1'b1;
   bit prev_stall   = 1'b0;
   logic [DATA_W-1:0] prev_dout = '0;

   ram_stream_reader #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Start     (Start),
      .StartAddr (StartAddr),
      .Len       (Len),
      .Busy      (Busy),
      .Done      (Done),
      .RA        (RA),
      .RdEn      (RdEn),
      .RD        (RD),
      .DOut      (DOut),
      .DValid    (DValid),
      .DReady    (DReady)
   );

   // Free-running clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Cycle counter used to relate Done to the last transfer.
   always @(posedge Clk) begin
      cyc <= cyc + 1;
   end

   // Behavioural RAM with a registered, enabled read port.
   always @(posedge Clk) begin
      if (RdEn) begin
         RD <= mem[RA];
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fillRam(input logic [7:0] key);
      data_key = key;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = 8'(i) ^ key;
      end
   endtask

   // Monitor: scoreboard reads and transfers, track buffer occupancy, check stall stability.
   always @(negedge Clk) begin
      int buffered;
      buffered = iss_lag1 - xfer_total;
      if (track) begin
         if (buffered > max_buf) max_buf = buffered;
         checkOutput("dvalid_vs_model", int'(DValid), int'(buffered != 0));
      end
      if (prev_stall) begin
         checkOutput("stall_dvalid", int'(DValid), 1);
         checkOutput("stall_dout", int'(DOut), int'(prev_dout));
      end
      iss_lag1 = iss_total;
      if (RdEn) begin
         if (ra_q.size() == 0) checkOutput("unexpected_read", int'(RA), -1);
         else checkOutput("ra", int'(RA), int'(ra_q.pop_front()));
         iss_total++;
      end
      if (DValid && DReady) begin
         if (data_q.size() == 0) checkOutput("unexpected_xfer", int'(DOut), -1);
         else checkOutput("dout", int'(DOut), int'(data_q.pop_front()));
         xfer_total++;
         last_xfer_cyc = cyc;
      end
      prev_stall = DValid && !DReady && !Rst;
      prev_dout  = DOut;
   end

   task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [ADDR_W:0] len,
                                input int words, input int done_ofs, input bit bp,
                                input bit poke, input int rst_at);
      int  done_k;
      int  done_cyc;
      int  rst_phase;
      bit  busy_seen;
      bit  finished;
      bit  saw_done;
      @(posedge Clk);
      #1;
      iss_total     = 0;
      iss_lag1      = 0;
      xfer_total    = 0;
      max_buf       = 0;
      last_xfer_cyc = -1;
      track         = 1'b1;
      Start         = 1'b1;
      StartAddr     = addr;
      Len           = len;
      DReady        = 1'b1;
      for (int i = 0; i < words; i++) begin
         ra_q.push_back(ADDR_W'(int'(addr) + i));
         data_q.push_back(8'(int'(addr) + i) ^ data_key);
      end
      done_k    = 0;
      done_cyc  = 0;
      rst_phase = 0;
      busy_seen = 1'b0;
      finished  = 1'b0;
      for (int k = 1; k <= MAX_CYCLES && !finished; k++) begin
         @(posedge Clk);
         #1;
         Start = poke && (k == 2);
         if (poke && k == 2) begin
            StartAddr = 11'h400;
            Len       = 12'd3;
         end
         DReady = bp ? (((k - 1) % 4) == 0) : 1'b1;
         if (rst_phase == 1) begin
            Rst       = 1'b0;
            track     = 1'b0;
            rst_phase = 2;
         end else if (rst_at > 0 && rst_phase == 0 && xfer_total >= rst_at) begin
            Rst       = 1'b1;
            rst_phase = 1;
         end
         @(negedge Clk);
         if (Busy) busy_seen = 1'b1;
         if (k == 1 && words > 0) begin
            checkOutput("busy_s1", int'(Busy), 1);
            checkOutput("rden_s1", int'(RdEn), 1);
            checkOutput("ra_s1", int'(RA), int'(addr));
         end
         if (rst_phase == 2) begin
            checkOutput("rst_dvalid", int'(DValid), 0);
            checkOutput("rst_busy", int'(Busy), 0);
            checkOutput("rst_rden", int'(RdEn), 0);
            checkOutput("rst_done", int'(Done), 0);
            finished = 1'b1;
         end else if (Done) begin
            done_k   = k;
            done_cyc = cyc;
            finished = 1'b1;
         end
      end
      if (!finished) begin
         checkOutput("done_timeout", 0, 1);
         ra_q.delete();
         data_q.delete();
      end else if (rst_phase == 2) begin
         ra_q.delete();
         data_q.delete();
         saw_done = 1'b0;
         for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            if (Done) saw_done = 1'b1;
         end
         checkOutput("no_done_after_rst", int'(saw_done), 0);
      end else begin
         if (done_ofs > 0) checkOutput("done_cycle", done_k, done_ofs);
         checkOutput("busy_at_done", int'(Busy), 0);
         checkOutput("words_moved", xfer_total, words);
         checkOutput("reads_issued", iss_total, words);
         if (words > 0) checkOutput("done_after_last", done_cyc, last_xfer_cyc + 1);
         else checkOutput("busy_never", int'(busy_seen), 0);
         checkOutput("queue_empty", data_q.size() + ra_q.size(), 0);
         @(posedge Clk);
         #1;
         @(negedge Clk);
         checkOutput("done_one_cycle", int'(Done), 0);
      end
   endtask

   // Main sequence: reset, table of bursts, then the multi-cycle corner cases.
   initial begin
      Rst       = 1'b1;
      Start     = 1'b0;
      StartAddr = '0;
      Len       = '0;
      DReady    = 1'b1;
      RD        = '0;
      fillRam(8'h00);

      vecs[0] = '{11'h010, 12'd4,    4,    7};
      vecs[1] = '{11'h7FE, 12'd4,    4,    7};
      vecs[2] = '{11'h000, 12'd0,    0,    1};
      vecs[3] = '{11'h055, 12'd1,    1,    4};
      vecs[4] = '{11'h123, 12'd2048, 2048, 2051};
      vecs[5] = '{11'h700, 12'd3000, 2048, 2051};

      repeat (2) @(posedge Clk);
      @(negedge Clk);
      checkOutput("reset_busy", int'(Busy), 0);
      checkOutput("reset_done", int'(Done), 0);
      checkOutput("reset_rden", int'(RdEn), 0);
      checkOutput("reset_ra", int'(RA), 0);
      checkOutput("reset_dvalid", int'(DValid), 0);
      checkOutput("reset_dout", int'(DOut), 0);
      @(posedge Clk);
      #1;
      Rst = 1'b0;

      for (int v = 0; v < 6; v++) begin
         $display("[TB] burst addr=%0h len=%0d", vecs[v].addr, vecs[v].len);
         applyStimulus(vecs[v].addr, vecs[v].len, vecs[v].words, vecs[v].done_ofs, 1'b0, 1'b0, 0);
      end

      $display("[TB] backpressure burst");
      applyStimulus(11'h020, 12'd8, 8, 0, 1'b1, 1'b0, 0);
      checkOutput("max_buffered_le3", int'(max_buf <= 3), 1);

      $display("[TB] start while busy");
      applyStimulus(11'h030, 12'd6, 6, 9, 1'b0, 1'b1, 0);

      $display("[TB] reset mid-burst");
      applyStimulus(11'h040, 12'd10, 10, 0, 1'b0, 1'b0, 3);

      $display("[TB] burst after reset with fresh data");
      fillRam(8'hA5);
      applyStimulus(11'h200, 12'd2, 2, 5, 1'b0, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
